sobel_stream_filter: RTL and testbench
======================================

# sobel_stream_filter

Parametrised streaming 3x3 Sobel edge filter for the pixel pipeline. It accepts a raster-order greyscale stream with a valid/ready handshake and frame-start marker, and buffers two lines internally. For every interior pixel it emits one gradient sample, selectable as |Gx|+|Gy|, |Gx|, |Gy| or a binary threshold. Output is saturated to the pixel width and tagged with end-of-line and end-of-frame flags. It replaces the fixed 8-bit, 128-wide, non-stallable filter in the image path.

## Interface
Parameters:
- DATA_W, 8: pixel width in bits, unsigned.
- IMG_W, 128: pixels per line; minimum 3.
- IMG_H, 128: lines per frame; minimum 3.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel present.
- in_ready  out  1  block can accept; `in_ready = !out_valid || out_ready`.
- in_sof  in  1  qualifies the pixel as the first pixel of a frame, at row 0, column 0.
- in_data  in  DATA_W  pixel value.
- mode  in  2  selects the output: 0 = |Gx|+|Gy|, 1 = |Gx|, 2 = |Gy|, 3 = threshold.
- threshold  in  DATA_W  compare level for mode 3.
- out_valid  out  1  output sample present; held until accepted.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  saturated gradient.
- out_eol  out  1  sample is the last of its output line.
- out_eof  out  1  sample is the last of the frame.

## Operation
- Accept: a pixel is accepted when `in_valid && in_ready`. Nothing changes state on cycles without an accept, except the output drain.
- Position counters:
  - The column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) give the position of the accepted pixel.
  - `col` wraps to 0 after IMG_W-1 and increments `row`.
  - `row` wraps to 0 after IMG_H-1.
  - An accepted pixel with `in_sof=1` is forced to (0,0), and counting continues from (0,1).
- Line buffers: two IMG_W x DATA_W line memories indexed by `col`.
  - On each accept, lb2[col] <= lb1[col] and lb1[col] <= in_data.
  - The memories are not cleared at reset or on sof. Row gating keeps stale data out of the output.
- Window:
  - A 3x3 register window shifts one column left on each accept.
  - The new right column is {lb2[col], lb1[col], in_data}, top to bottom.
  - The gradient is computed on the updated window, which includes the pixel just accepted.
- Emit rule:
  - An accept at row>=2 and col>=2 produces a sample centred on (row-1, col-1).
  - Each frame therefore yields (IMG_W-2)*(IMG_H-2) samples. Border pixels produce no output.
- Arithmetic:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - Both are signed, DATA_W+3 bits. The magnitude sum is unsigned, DATA_W+4 bits.
  - Result = min(selected value, 2^DATA_W-1).
  - Mode 3: out_data = all-ones if (|Gx|+|Gy|) >= threshold, else 0. The comparison uses the unsaturated sum.
- Sampling: `mode` and `threshold` are sampled at the accept that produces the sample.
- Flags: out_eol=1 when the producing accept had col==IMG_W-1. out_eof=1 when it also had row==IMG_H-1.

## Timing
- Reset values: out_valid=0, out_data=0, out_eol=0, out_eof=0, col=0, row=0, window=0. Consequently in_ready=1 in the cycle after reset.
- Latency: the sample appears on the output registers the cycle after the producing accept.
- Throughput: one pixel per cycle when out_ready is held at 1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0.
  - out_data, out_eol and out_eof are held stable.
- Simultaneous drain and accept: when the output is drained and a pixel is accepted in the same cycle, out_valid stays 1 with the new sample if the accept emits. Otherwise out_valid goes to 0.
- Reset mid-frame: rst=1 drops any pending output at once. The next accepted pixel is treated as (0,0), whether or not sof is asserted.
- Sof mid-frame: sof on an accepted pixel at any position restarts the counters. No sample is emitted until row>=2 and col>=2 of the new frame.
- Sof and frame-wrap coinciding: when in_sof arrives on the same accept as the natural frame wrap, it is consistent with the wrap and produces no special behaviour.

## Configuration
- SOBEL_THRESHOLD_EN:
  - Defined: mode 3 is the threshold mode as specified above.
  - Undefined: the comparator is not built, the `threshold` port is ignored, and mode 3 behaves exactly as mode 0.

## Test plan
All scenarios use IMG_W=8, IMG_H=6 and DATA_W=8 unless stated.
- Uniform frame, all pixels 77, mode 0, out_ready=1:
  - 24 samples, all 0.
  - out_eol on every 6th sample; out_eof on the 24th only.
  - out_valid=1 exactly one cycle after each producing accept.
- Vertical step, columns 0-3 = 0 and columns 4-7 = 50, mode 0:
  - Each output line is 0,0,200,200,0,0.
  - Mode 2 gives all zeros; mode 1 matches mode 0.
- Vertical step of 0/255, mode 0:
  - The raw value of 1020 saturates to 255 at centre columns 3 and 4.
  - With SOBEL_THRESHOLD_EN, mode 3 and threshold=201 on the 0/50 step gives all zeros. Threshold=200 gives 255 at centre columns 3 and 4.
- Random out_ready (50%) over a random frame:
  - Output sequence is identical to the out_ready=1 run.
  - No sample is lost or duplicated.
  - Output is stable during every stall, and in_ready=0 whenever out_valid && !out_ready.
- Sof asserted at row 3, column 5, then a full frame of gradient data:
  - No samples appear until the new row 2, column 2.
  - The new frame yields exactly 24 samples, matching a clean-start reference.
- rst pulsed with out_valid=1 held by out_ready=0 mid-frame:
  - The next cycle shows out_valid=0 and in_ready=1.
  - A following frame sent without sof produces the correct 24 samples.

Source files
------------

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter with two internal line buffers and a
// valid/ready handshake on both sides. One gradient sample is produced per
// interior pixel, saturated to DATA_W bits and tagged with end-of-line and
// end-of-frame flags.
// Optional feature macro: SOBEL_THRESHOLD_EN (mode 3 becomes a binary
// threshold on |Gx|+|Gy|; when undefined, mode 3 behaves as mode 0).
module sobel_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_eol_q, out_eof_q;
    logic              accept, emit;
    logic [GW-1:0]     gx, gy, ax, ay;
    logic [MW-1:0]     mag_x, mag_y, mag_sum, sel;
    logic [DATA_W-1:0] result;

    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return {3'b000, p};
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // sof forces the accepted pixel to the frame origin
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign emit    = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    assign lb1_rd = lb1_q[cur_col];
    assign lb2_rd = lb2_q[cur_col];

    // raster position of the next pixel
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // window shifts left, new right column comes from the line buffers
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = in_data;
        end
    end

    // gradient on the updated window, magnitude selection and saturation
    always_comb begin
        gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) << 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[1][0]) << 1) + ext(win_d[2][0]));
        gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) << 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[0][1]) << 1) + ext(win_d[0][2]));
        ax = gx[GW-1] ? (~gx + 1'b1) : gx;
        ay = gy[GW-1] ? (~gy + 1'b1) : gy;
        mag_x   = {1'b0, ax};
        mag_y   = {1'b0, ay};
        mag_sum = mag_x + mag_y;
        case (mode)
            2'd1:    sel = mag_x;
            2'd2:    sel = mag_y;
            default: sel = mag_sum;
        endcase
        result = (|sel[MW-1:DATA_W]) ? '1 : sel[DATA_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        // threshold compares the unsaturated sum
        if (mode == 2'd3) begin
            result = (mag_sum >= {4'b0000, threshold}) ? '1 : '0;
        end
`endif
    end

`ifndef SOBEL_THRESHOLD_EN
    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    // position counters and window registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
        end
    end

    // line memories are never cleared; row gating hides stale contents
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb2_q[cur_col] <= lb1_rd;
            lb1_q[cur_col] <= in_data;
        end
    end

    // output register: loads whenever the slot is free or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (in_ready) begin
            out_valid_q <= emit;
            if (emit) begin
                out_data_q <= result;
                out_eol_q  <= (cur_col == COL_LAST);
                out_eof_q  <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter (8x6 image, 8-bit pixels).
module tb_sobel_stream_filter;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0, threshold = '0;
    logic [1:0] mode = 2'd0;
    logic       in_ready, out_valid, out_eol, out_eof;
    logic [7:0] out_data;

    sobel_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_data(in_data), .mode(mode), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .out_eof(out_eof));

    always #5 clk = ~clk;

    typedef struct { int d; bit eol; bit eof; } samp_t;

    int    n_tests = 0, n_fail = 0;
    samp_t exp_q[$], got[$], ref_q[$];
    int    img [H][W];
    int    frm [H][W];
    int    mrow = 0, mcol = 0;
    bit    chk_en = 0, have_pred = 0, pred_valid = 0, prev_stall = 0;
    bit    rand_ready = 0, rand_mode = 0, gap_en = 0;
    logic [7:0] prev_d;
    logic  prev_eol, prev_eof;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, expv, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel sample centred on (r-1, c-1) straight from the stored image
    function automatic int sobel_ref(input int r, input int c, input int md, input int thr);
        int p [3][3];
        int gxv, gyv, s, v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gxv = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gyv = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        s = iabs(gxv) + iabs(gyv);
        case (md)
            1: v = iabs(gxv);
            2: v = iabs(gyv);
            default: v = s;
        endcase
        if (v > 255) v = 255;
`ifdef SOBEL_THRESHOLD_EN
        if (md == 3) v = (s >= thr) ? 255 : 0;
`endif
        return v;
    endfunction

    // single compare/model process, sampled on the falling edge
    always @(negedge clk) begin
        bit emit;
        samp_t e, g;
        int r, c;
        if (chk_en) begin
            if (have_pred) chk("out_valid_timing", out_valid, pred_valid);
            if (prev_stall) begin
                chk("stall_data", out_data, prev_d);
                chk("stall_eol", out_eol, prev_eol);
                chk("stall_eof", out_eof, prev_eof);
            end
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
        end
        if (rst) begin
            exp_q.delete();
            mrow = 0; mcol = 0;
            have_pred = 1; pred_valid = 0; prev_stall = 0;
        end else begin
            emit = 0;
            if (out_valid && out_ready) begin
                g.d = out_data; g.eol = out_eol; g.eof = out_eof;
                got.push_back(g);
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_data", out_data, e.d);
                    chk("sample_eol", out_eol, e.eol);
                    chk("sample_eof", out_eof, e.eof);
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin mrow = 0; mcol = 0; end
                r = mrow; c = mcol;
                img[r][c] = in_data;
                if (r >= 2 && c >= 2) begin
                    e.d = sobel_ref(r, c, mode, threshold);
                    e.eol = (c == W-1);
                    e.eof = (c == W-1) && (r == H-1);
                    exp_q.push_back(e);
                    emit = 1;
                end
                mcol = c + 1;
                if (mcol == W) begin
                    mcol = 0;
                    mrow = (r == H-1) ? 0 : r + 1;
                end
            end
            pred_valid = emit || (out_valid && !out_ready);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_eol = out_eol; prev_eof = out_eof;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = $urandom_range(0, 1);
    end

    task automatic send_px(input int d, input bit s);
        int guard = 0;
        logic acc;
        in_valid = 1; in_data = d[7:0]; in_sof = s;
        if (rand_mode) begin
            mode = 2'($urandom_range(0, 3));
            threshold = 8'($urandom_range(0, 255));
        end
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 0; in_sof = 0;
        if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input bit sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_px(frm[r][c], sof && r == 0 && c == 0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 500) chk("drain_timeout", 0, 1);
    endtask

    task automatic run_frame(input int md, input int thr);
        mode = 2'(md); threshold = 8'(thr);
        got.delete();
        send_frame(1);
        drain();
    endtask

    task automatic chk_step(input string name, input int hi);
        chk({name, "_count"}, got.size(), 24);
        for (int i = 0; i < got.size() && i < 24; i++) begin
            chk({name, "_val"}, got[i].d, ((i % 6) == 2 || (i % 6) == 3) ? hi : 0);
        end
    endtask

    task automatic cmp_seq(input string name);
        chk({name, "_len"}, got.size(), ref_q.size());
        for (int i = 0; i < got.size() && i < ref_q.size(); i++) begin
            chk({name, "_d"}, got[i].d, ref_q[i].d);
            chk({name, "_eol"}, got[i].eol, ref_q[i].eol);
            chk({name, "_eof"}, got[i].eof, ref_q[i].eof);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_eol", out_eol, 0);
        chk("reset_out_eof", out_eof, 0);
        @(posedge clk); #1;

        // uniform frame
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frm[r][c] = 77;
        run_frame(0, 0);
        chk("uniform_count", got.size(), 24);
        for (int i = 0; i < got.size(); i++) begin
            chk("uniform_val", got[i].d, 0);
            chk("uniform_eol", got[i].eol, (i % 6) == 5);
            chk("uniform_eof", got[i].eof, i == 23);
        end

        // vertical steps
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frm[r][c] = (c >= 4) ? 50 : 0;
        run_frame(0, 0);  chk_step("step50_m0", 200);
        run_frame(1, 0);  chk_step("step50_m1", 200);
        run_frame(2, 0);  chk_step("step50_m2", 0);
`ifdef SOBEL_THRESHOLD_EN
        run_frame(3, 201); chk_step("thr201", 0);
        run_frame(3, 200); chk_step("thr200", 255);
`else
        run_frame(3, 201); chk_step("m3_as_m0", 200);
`endif
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frm[r][c] = (c >= 4) ? 255 : 0;
        run_frame(0, 0);  chk_step("step255_sat", 255);

        // random frame, full-rate then random backpressure
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frm[r][c] = $urandom_range(0, 255);
        run_frame(0, 0);
        ref_q = got;
        gap_en = 1; rand_ready = 1;
        run_frame(0, 0);
        rand_ready = 0; out_ready = 1;
        cmp_seq("backpressure");
        rand_mode = 1; rand_ready = 1;
        run_frame(0, 0);
        chk("randmode_count", got.size(), 24);
        rand_mode = 0; rand_ready = 0; out_ready = 1; gap_en = 0; mode = 0;

        // sof mid-frame at row 3 column 5
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frm[r][c] = (r * 37 + c * 23) % 256;
        run_frame(0, 0);
        ref_q = got;
        for (int i = 0; i < 3 * W + 5; i++) send_px($urandom_range(0, 255), i == 0);
        drain();
        got.delete();
        send_frame(1);
        drain();
        cmp_seq("sof_restart");

        // reset while a sample is held by backpressure
        out_ready = 0;
        for (int i = 0; i < 2 * W + 3; i++) send_px($urandom_range(0, 255), i == 0);
        @(negedge clk);
        chk("held_before_rst", out_valid, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1;
        @(posedge clk); #1;
        got.delete();
        send_frame(0);
        drain();
        cmp_seq("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
